// File: rtl/io_pkg.sv
// Shared I/O constants and debouncer state type.
// Used by the input conditioner and the I/O memory block.
package io_pkg;

   localparam int GPIO_W = 36;
   localparam int SW_W   = 4;

   typedef enum logic [1:0] {
      STABLE0,
      WAIT1,
      STABLE1,
      WAIT0
   } deb_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Single-switch debouncer on an already synchronised input.
// A new level is accepted only after DEBOUNCE_CYCLES stable samples.
module switch_debouncer
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic sync,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   deb_state_t      state;
   logic [CW-1:0]   cnt;

   // Qualification FSM with registered level and edge pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= STABLE0;
         cnt   <= '0;
         db    <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         unique case (state)
            STABLE0: begin
               if (sync) begin
                  state <= WAIT1;
                  cnt   <= ONE;
               end else begin
                  cnt <= '0;
               end
            end
            WAIT1: begin
               if (!sync) begin
                  state <= STABLE0;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= STABLE1;
                  cnt   <= '0;
                  db    <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            STABLE1: begin
               if (!sync) begin
                  state <= WAIT0;
                  cnt   <= ONE;
               end else begin
                  cnt <= '0;
               end
            end
            WAIT0: begin
               if (sync) begin
                  state <= STABLE1;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= STABLE0;
                  cnt   <= '0;
                  db    <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state <= STABLE0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronises GPIO pins and debounces slide switches
// before they reach the I/O memory map.
module io_input_conditioner
   import io_pkg::*;
#(
   parameter int GPIO_W          = io_pkg::GPIO_W,
   parameter int SW_W            = io_pkg::SW_W,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] gpio_raw,
   input  logic [SW_W-1:0]   switches_raw,
   output logic [GPIO_W-1:0] gpio_sync,
   output logic              gpio_changed,
   output logic [SW_W-1:0]   switches_db,
   output logic [SW_W-1:0]   sw_rise,
   output logic [SW_W-1:0]   sw_fall
);

   logic [GPIO_W-1:0] gpio_s1;
   logic [GPIO_W-1:0] gpio_prev;
   logic [SW_W-1:0]   sw_s1;
   logic [SW_W-1:0]   sw_s2;

   // Two-flop synchronisers plus previous GPIO value
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_s1   <= '0;
         gpio_sync <= '0;
         gpio_prev <= '0;
         sw_s1     <= '0;
         sw_s2     <= '0;
      end else begin
         gpio_s1   <= gpio_raw;
         gpio_sync <= gpio_s1;
         gpio_prev <= gpio_sync;
         sw_s1     <= switches_raw;
         sw_s2     <= sw_s1;
      end
   end

   // Change flag derives only from registers
   assign gpio_changed = |(gpio_sync ^ gpio_prev);

   for (genvar i = 0; i < SW_W; i++) begin : g_deb
      switch_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .sync (sw_s2[i]),
         .db   (switches_db[i]),
         .rise (sw_rise[i]),
         .fall (sw_fall[i])
      );
   end

endmodule
